ly_2257_7_key: RTL and testbench
================================

LY_2257_7_KEY -- requirements
Module: ly_2257_7_key

Interface
REQ-001 SHALL parameter TICK_DIV, 50000, clk_in cycles per sample tick (1 kHz at 50 MHz); legal range 2..2^20.
REQ-002 SHALL parameter STABLE_TICKS, 20, consecutive equal samples required to accept a change; legal range 2..255.
REQ-003 SHALL port clk_in, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL port key_raw, input, 14, raw buttons, active-low (0 = pressed); bit i = note i.
REQ-006 SHALL port Key, output, 14, debounced one-hot note for the downstream segment decoder; all-zero means none.
REQ-007 SHALL port key_code, output, 4, binary index+1 of the asserted Key bit; 0 when Key is zero.
REQ-008 SHALL port key_strobe, output, 1, one-cycle pulse when a new note is accepted.
REQ-009 SHALL port key_busy, output, 1, high in CHECK_PRESS or CHECK_RELEASE.

Function
REQ-010 SHALL invert key_raw, then pass it through a two-flop synchronizer; only the synchronized vector (sync) is used.
REQ-011 SHALL run a free-running tick counter 0..TICK_DIV-1, with tick high for one cycle at TICK_DIV-1; all FSM decisions occur only on tick cycles.
REQ-012 SHALL run a 4-state FSM: IDLE, CHECK_PRESS, HELD, CHECK_RELEASE; cand is a 14-bit register and cnt is an 8-bit register.
REQ-013 IDLE: on tick with sync != 0, the FSM SHALL load cand=sync, set cnt=1, and go to CHECK_PRESS.
REQ-014 CHECK_PRESS: on tick, if sync==0 the FSM SHALL go to IDLE; if sync!=cand it SHALL load cand=sync and set cnt=1; otherwise it SHALL increment cnt.
REQ-015 When cnt reaches STABLE_TICKS in CHECK_PRESS, the FSM SHALL enter HELD, update Key/key_code the same cycle, and pulse key_strobe.
REQ-016 Multiple bits in cand SHALL resolve by priority, lowest index wins (bits 0 and 5 pressed -> Key=14'h0001, key_code=1).
REQ-017 HELD: on tick with sync!=cand, the FSM SHALL load the new value into a shadow register, set cnt=1, and go to CHECK_RELEASE; Key holds.
REQ-018 CHECK_RELEASE: on tick, if sync==cand (glitch) the FSM SHALL return to HELD with no strobe; if sync differs from the shadow it SHALL reload the shadow and set cnt=1; otherwise it SHALL increment cnt.
REQ-019 When cnt reaches STABLE_TICKS in CHECK_RELEASE: if shadow==0, the FSM SHALL go to IDLE and apply the release rule (REQ-026); else it SHALL load cand=shadow, go to HELD, update Key, and pulse key_strobe only if the resolved index changed.
REQ-020 Worst-case press latency SHALL be 2 + TICK_DIV*STABLE_TICKS clk_in cycles from the key_raw edge; minimum latency SHALL be 2 + TICK_DIV*(STABLE_TICKS-1) + 1.
REQ-021 Key SHALL always be exactly one-hot or zero; key_code SHALL always equal index(Key)+1 or 0.
REQ-022 cnt SHALL saturate at STABLE_TICKS and never wrap.

Reset
REQ-023 While rst_n is 0, the block SHALL force Key=0, key_code=0, key_strobe=0, key_busy=0, FSM=IDLE, cand=0, shadow=0, cnt=0, tick counter=0, and both synchronizer stages=0 (released).
REQ-024 Reset mid-debounce SHALL discard progress; after release, a held key SHALL require full debounce again.
REQ-025 Reset deassertion SHALL be synchronized to clk_in; no strobe SHALL occur on the deassertion cycle.

Configuration
REQ-026 SHALL support macro KEY_LATCH_EN. Defined: on release to IDLE, Key/key_code SHALL retain the last note until a new note is accepted. Undefined: Key/key_code SHALL clear to 0 on the cycle of entry to IDLE.
REQ-027 KEY_LATCH_EN SHALL NOT affect key_strobe, key_busy, or debounce timing.

Verification (TICK_DIV=4, STABLE_TICKS=3)
REQ-028 Press bit 2 (key_raw=14'h3FFB) held -> within 14 cycles Key=14'h0004, key_code=3, one key_strobe pulse.
REQ-029 Bit 2 bounces 1-tick low/high for 5 ticks, then stable -> no strobe during bounce; exactly one strobe after 3 stable ticks.
REQ-030 Bits 0 and 7 pressed together -> Key=14'h0001, key_code=1; then release bit 0 with bit 7 held -> after 3 ticks Key=14'h0080, key_code=8, one strobe.
REQ-031 Release all keys from Key=14'h0004 -> after 3 ticks: without KEY_LATCH_EN Key=0, key_code=0; with it Key stays 14'h0004; no strobe either way.
REQ-032 Assert rst_n=0 in CHECK_PRESS (cnt=2) -> all outputs 0 immediately; release with key still held -> strobe only after 3 further stable ticks.

Source files
------------

// File: rtl/ly_2257_7_key.sv
// ---------------------------------------------------------------------------
// ly_2257_7_key -- 14-button note keypad debouncer.
//
// Raw active-low buttons are inverted and synchronized. A slow sample tick
// drives a four-state debounce FSM. The FSM publishes a one-hot note on Key
// (lowest index wins), its binary code (index+1), and a one-cycle strobe each
// time a new note is accepted.
//
// Parameters
//   TICK_DIV      clk_in cycles per sample tick (2 .. 2^20)
//   STABLE_TICKS  consecutive equal samples needed to accept a change (2..255)
//
// Ports
//   clk_in      in   1  sole clock, rising edge
//   rst_n       in   1  asynchronous active-low reset, deassertion synchronized
//   key_raw     in  14  raw buttons, 0 = pressed, bit i = note i
//   Key         out 14  debounced one-hot note, zero = none
//   key_code    out  4  index+1 of the asserted Key bit, 0 when Key is zero
//   key_strobe  out  1  one-cycle pulse when a new note is accepted
//   key_busy    out  1  high while a press or release is being qualified
//
// Build option
//   KEY_LATCH_EN  when defined, Key/key_code keep the last note after all
//                 buttons are released; otherwise they clear on release.
// ---------------------------------------------------------------------------
module ly_2257_7_key #(
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 20
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic [13:0] key_raw,
  output logic [13:0] Key,
  output logic [3:0]  key_code,
  output logic        key_strobe,
  output logic        key_busy
);

  localparam int               DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [7:0]       STABLE   = 8'(STABLE_TICKS);

  typedef enum logic [1:0] {
    IDLE,
    CHECK_PRESS,
    HELD,
    CHECK_RELEASE
  } state_t;

  logic             rst_meta;
  logic             rst_sync_n;
  logic [13:0]      sync_meta;
  logic [13:0]      sync;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  state_t      state, state_nxt;
  logic [13:0] cand, cand_nxt;
  logic [13:0] shadow, shadow_nxt;
  logic [7:0]  cnt, cnt_nxt, cnt_inc;
  logic [13:0] key_nxt;
  logic [3:0]  code_nxt;
  logic        strobe_nxt;
  logic [3:0]  cand_code;
  logic [3:0]  shadow_code;

  // Lowest set bit wins; result is index+1, or 0 for an empty vector.
  function automatic logic [3:0] lowest_code(input logic [13:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 13; i >= 0; i--) begin
      if (v[i]) c = 4'(i + 1);
    end
    return c;
  endfunction

  function automatic logic [13:0] code_to_onehot(input logic [3:0] c);
    logic [13:0] k;
    k = '0;
    for (int i = 0; i < 14; i++) begin
      k[i] = (c == 4'(i + 1));
    end
    return k;
  endfunction

  // Reset asserts asynchronously but is released only on a clock edge, so
  // the rest of the block never leaves reset in the middle of a cycle.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta   <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_sync_n <= rst_meta;
    end
  end

  // Buttons are inverted so that 1 means pressed from here on.
  always_ff @(posedge clk_in or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= ~key_raw;
      sync      <= sync_meta;
    end
  end

  always_ff @(posedge clk_in or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign tick        = (div_cnt == DIV_LAST);
  assign cand_code   = lowest_code(cand);
  assign shadow_code = lowest_code(shadow);
  assign key_busy    = (state == CHECK_PRESS) || (state == CHECK_RELEASE);

  always_ff @(posedge clk_in or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state      <= IDLE;
      cand       <= '0;
      shadow     <= '0;
      cnt        <= '0;
      Key        <= '0;
      key_code   <= '0;
      key_strobe <= 1'b0;
    end else begin
      state      <= state_nxt;
      cand       <= cand_nxt;
      shadow     <= shadow_nxt;
      cnt        <= cnt_nxt;
      Key        <= key_nxt;
      key_code   <= code_nxt;
      key_strobe <= strobe_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cand_nxt   = cand;
    shadow_nxt = shadow;
    cnt_nxt    = cnt;
    key_nxt    = Key;
    code_nxt   = key_code;
    strobe_nxt = 1'b0;
    // Saturating increment: the sample count never wraps past STABLE.
    cnt_inc    = (cnt >= STABLE) ? STABLE : cnt + 8'd1;

    if (tick) begin
      case (state)
        IDLE: begin
          if (sync != '0) begin
            cand_nxt  = sync;
            cnt_nxt   = 8'd1;
            state_nxt = CHECK_PRESS;
          end
        end

        CHECK_PRESS: begin
          if (sync == '0) begin
            cnt_nxt   = 8'd0;
            state_nxt = IDLE;
`ifndef KEY_LATCH_EN
            key_nxt   = '0;
            code_nxt  = 4'd0;
`endif
          end else if (sync != cand) begin
            cand_nxt = sync;
            cnt_nxt  = 8'd1;
          end else begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == STABLE) begin
              state_nxt  = HELD;
              code_nxt   = cand_code;
              key_nxt    = code_to_onehot(cand_code);
              strobe_nxt = 1'b1;
            end
          end
        end

        HELD: begin
          if (sync != cand) begin
            shadow_nxt = sync;
            cnt_nxt    = 8'd1;
            state_nxt  = CHECK_RELEASE;
          end
        end

        CHECK_RELEASE: begin
          if (sync == cand) begin
            // Input fell back to the accepted value: treat it as a glitch.
            cnt_nxt   = STABLE;
            state_nxt = HELD;
          end else if (sync != shadow) begin
            shadow_nxt = sync;
            cnt_nxt    = 8'd1;
          end else begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == STABLE) begin
              if (shadow == '0) begin
                cand_nxt  = '0;
                cnt_nxt   = 8'd0;
                state_nxt = IDLE;
`ifndef KEY_LATCH_EN
                key_nxt   = '0;
                code_nxt  = 4'd0;
`endif
              end else begin
                // Key already shows cand's note, so only a change of the
                // winning index is announced.
                cand_nxt   = shadow;
                state_nxt  = HELD;
                code_nxt   = shadow_code;
                key_nxt    = code_to_onehot(shadow_code);
                strobe_nxt = (shadow_code != key_code);
              end
            end
          end
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ly_2257_7_key.sv
// ---------------------------------------------------------------------------
// tb_ly_2257_7_key -- self-checking bench for ly_2257_7_key with
// TICK_DIV=4 and STABLE_TICKS=3.
//
// Reference model: a change is accepted once the last STABLE_TICKS tick
// samples are all equal and differ from the accepted value; busy means the
// latest sample differs from the accepted value.
// ---------------------------------------------------------------------------
module tb_ly_2257_7_key;

  localparam int TD = 4;
  localparam int ST = 3;
`ifdef KEY_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic [13:0] key_raw;
  logic [13:0] key_o;
  logic [3:0]  code_o;
  logic        strobe_o;
  logic        busy_o;

  int checks   = 0;
  int failures = 0;
  int strobe_seen = 0;

  always #5 clk_in = ~clk_in;

  ly_2257_7_key #(.TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .key_raw   (key_raw),
    .Key       (key_o),
    .key_code  (code_o),
    .key_strobe(strobe_o),
    .key_busy  (busy_o)
  );

  // Reference model state
  logic [13:0] m_key, m_acc, m_last, m_p0, m_p1;
  logic [3:0]  m_code;
  logic        m_strobe, m_busy;
  logic [13:0] m_hist[$];
  int          m_rel, m_phase;

  typedef struct {
    logic [13:0] raw;
    int          cycles;
    logic [13:0] key_plain;
    logic [13:0] key_latch;
    logic [3:0]  code_plain;
    logic [3:0]  code_latch;
    int          strobes;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [13:0] actual,
                             input logic [13:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkCount(input string name, input int actual, input int lo, input int hi);
    checks++;
    if (actual < lo || actual > hi) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0d required=%0d..%0d at %0t", name, actual, lo, hi, $time);
    end
  endtask

  function automatic int lowestIdx(input logic [13:0] v);
    for (int i = 0; i < 14; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic modelReset();
    m_key = '0; m_code = '0; m_strobe = 1'b0; m_busy = 1'b0;
    m_acc = '0; m_last = '0; m_p0 = '0; m_p1 = '0;
    m_hist.delete();
    m_rel = 0; m_phase = 0;
  endtask

  task automatic modelAccept(input logic [13:0] v);
    int pi, ni;
    pi = lowestIdx(m_acc);
    ni = lowestIdx(v);
    if (v == '0) begin
      if (!LATCH) begin
        m_key  = '0;
        m_code = '0;
      end
    end else begin
      m_strobe = (m_acc == '0) || (ni != pi);
      m_key    = 14'(1) << ni;
      m_code   = 4'(ni + 1);
    end
    m_acc = v;
  endtask

  task automatic modelEdge();
    logic [13:0] s;
    bit same;
    m_strobe = 1'b0;
    if (rst_n !== 1'b1) begin
      m_rel = 0;
      return;
    end
    // Two edges of reset release, then the logic runs.
    if (m_rel < 3) m_rel++;
    if (m_rel < 3) return;
    s = m_p1; m_p1 = m_p0; m_p0 = ~key_raw;
    if (m_phase % TD == TD - 1) begin
      m_hist.push_back(s);
      if (m_hist.size() > ST) void'(m_hist.pop_front());
      m_last = s;
      if (m_hist.size() == ST && s != m_acc) begin
        same = 1'b1;
        foreach (m_hist[i]) if (m_hist[i] != s) same = 1'b0;
        if (same) modelAccept(s);
      end
    end
    m_busy = (m_last != m_acc);
    m_phase++;
  endtask

  task automatic stepCycle();
    @(posedge clk_in);
    modelEdge();
    @(negedge clk_in);
    checkOutput("Key", key_o, m_key);
    checkOutput("key_code", {10'b0, code_o}, {10'b0, m_code});
    checkOutput("key_strobe", {13'b0, strobe_o}, {13'b0, m_strobe});
    checkOutput("key_busy", {13'b0, busy_o}, {13'b0, m_busy});
    if (strobe_o === 1'b1) strobe_seen++;
  endtask

  task automatic applyStimulus(input logic [13:0] raw, input int n);
    key_raw = raw;
    repeat (n) stepCycle();
  endtask

  initial begin
    int k;
    bit got;
    logic [13:0] raw;

    vecs[0] = '{14'h3FFF, 20, 14'h0000, 14'h0000, 4'd0,  4'd0,  0};
    vecs[1] = '{14'h3FFB, 16, 14'h0004, 14'h0004, 4'd3,  4'd3,  1};
    vecs[2] = '{14'h3FFF, 16, 14'h0000, 14'h0004, 4'd0,  4'd3,  0};
    vecs[3] = '{14'h3F7E, 16, 14'h0001, 14'h0001, 4'd1,  4'd1,  1};
    vecs[4] = '{14'h3F7F, 16, 14'h0080, 14'h0080, 4'd8,  4'd8,  1};
    vecs[5] = '{14'h3F77, 16, 14'h0008, 14'h0008, 4'd4,  4'd4,  1};
    vecs[6] = '{14'h1FF7, 16, 14'h0008, 14'h0008, 4'd4,  4'd4,  0};
    vecs[7] = '{14'h3FFF, 16, 14'h0000, 14'h0008, 4'd0,  4'd4,  0};
    vecs[8] = '{14'h1FFF, 16, 14'h2000, 14'h2000, 4'd14, 4'd14, 1};
    vecs[9] = '{14'h3FFF, 16, 14'h0000, 14'h2000, 4'd0,  4'd14, 0};

    rst_n = 1'b1;
    key_raw = 14'h3FFF;
    #2 rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("reset Key", key_o, 14'h0000);
    checkOutput("reset key_code", {10'b0, code_o}, 14'h0000);
    checkOutput("reset key_strobe", {13'b0, strobe_o}, 14'h0000);
    checkOutput("reset key_busy", {13'b0, busy_o}, 14'h0000);
    repeat (4) stepCycle();
    rst_n = 1'b1;

    $display("[TB] vector table");
    for (int v = 0; v < 10; v++) begin
      strobe_seen = 0;
      applyStimulus(vecs[v].raw, vecs[v].cycles);
      checkOutput($sformatf("vec%0d Key", v), key_o, LATCH ? vecs[v].key_latch : vecs[v].key_plain);
      checkOutput($sformatf("vec%0d key_code", v), {10'b0, code_o},
                  {10'b0, (LATCH ? vecs[v].code_latch : vecs[v].code_plain)});
      checkCount($sformatf("vec%0d strobes", v), strobe_seen, vecs[v].strobes, vecs[v].strobes);
    end

    $display("[TB] press latency");
    strobe_seen = 0;
    key_raw = 14'h3FFB;
    k = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      stepCycle();
      k++;
      if (strobe_o === 1'b1) got = 1'b1;
    end
    checkCount("press latency", k, 2 + TD * (ST - 1) + 1, 2 + TD * ST);
    applyStimulus(14'h3FFB, 8);
    checkCount("press strobes", strobe_seen, 1, 1);
    checkOutput("press Key", key_o, 14'h0004);

    $display("[TB] release and bounce");
    strobe_seen = 0;
    applyStimulus(14'h3FFF, 16);
    checkOutput("release Key", key_o, LATCH ? 14'h0004 : 14'h0000);
    checkCount("release strobes", strobe_seen, 0, 0);
    for (int seg = 0; seg < 6; seg++) begin
      applyStimulus((seg % 2 == 0) ? 14'h3FFB : 14'h3FFF, TD);
    end
    checkCount("bounce strobes", strobe_seen, 0, 0);
    applyStimulus(14'h3FFB, 16);
    checkCount("settled strobes", strobe_seen, 1, 1);
    checkOutput("settled Key", key_o, 14'h0004);

    $display("[TB] reset during press qualification");
    applyStimulus(14'h3FFF, 16);
    strobe_seen = 0;
    key_raw = 14'h3FFB;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      stepCycle();
      if (busy_o === 1'b1) got = 1'b1;
    end
    checkCount("busy rises", int'(got), 1, 1);
    repeat (TD) stepCycle();
    checkCount("no early strobe", strobe_seen, 0, 0);
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("midreset Key", key_o, 14'h0000);
    checkOutput("midreset key_code", {10'b0, code_o}, 14'h0000);
    checkOutput("midreset key_strobe", {13'b0, strobe_o}, 14'h0000);
    checkOutput("midreset key_busy", {13'b0, busy_o}, 14'h0000);
    repeat (3) stepCycle();
    rst_n = 1'b1;
    k = 0;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      stepCycle();
      k++;
      if (strobe_o === 1'b1) got = 1'b1;
    end
    // 2 edges of reset release, tick on the 4th running edge, 3 samples.
    checkCount("post-reset latency", k, 2 + TD * ST, 2 + TD * ST);
    checkOutput("post-reset Key", key_o, 14'h0004);

    $display("[TB] random stimulus");
    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: raw = 14'h3FFF;
        3, 4, 5: raw = ~(14'(1) << $urandom_range(0, 13));
        6, 7:    raw = ~((14'(1) << $urandom_range(0, 13)) | (14'(1) << $urandom_range(0, 13)));
        default: raw = 14'($urandom);
      endcase
      applyStimulus(raw, $urandom_range(1, 18));
    end
    applyStimulus(14'h3FFF, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
